ser_des_link: RTL
=================

Name: ser_des_link

Overview:
- Parametrised, full-duplex serial link block. It is the next generation of the fixed 8-bit serializer/deserializer pair.
- TX path: accepts parallel words over a valid/ready handshake and emits framed NRZ bits (start, data LSB-first, stop), each bit held CLKS_PER_BIT cycles.
- RX path: synchronises the serial input, mid-bit samples it, checks framing, and presents words through a one-entry holding register with overrun detection.
- Internal loopback mode lets the system bench close the link without external wiring.

Parameters:
- DATA_W, 8, data bits per frame (valid range 5..16).
- CLKS_PER_BIT, 4, clock cycles per serial bit (>=4, even).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX idle, able to accept a word.
- ser_out  out  1  serial line out; idles high.
- ser_in  in  1  serial line in; asynchronous to clk.
- loopback  in  1  1: RX samples ser_out internally and ignores ser_in.
- rx_data  out  DATA_W  last received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: a word arrived while rx_valid=1; cleared by reset only.

Behaviour:
- Reset values: tx_ready=1, ser_out=1, rx_data=0, rx_valid=0, frame_err=0, overrun=0. Both FSMs return to IDLE; sync flops are preset to 1.
- Reset asserted mid-frame aborts immediately; ser_out is high on the cycle after reset.
- Frame: start(0), DATA_W data bits LSB first, [parity], stop(1). Frame length F = (DATA_W+2[+1])*CLKS_PER_BIT cycles.
- TX FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Handshake: a word is accepted on a cycle with tx_valid&tx_ready; tx_data is latched and tx_ready drops to 0 on the next cycle.
  - ser_out drives the start bit from the cycle after acceptance.
  - Each bit lasts exactly CLKS_PER_BIT cycles (bit counter wraps at CLKS_PER_BIT-1).
  - tx_ready returns to 1 on the last cycle of the stop bit, so back-to-back frames have no idle gap.
  - tx_data changes while tx_ready=0 are ignored.
- RX input: 2-FF synchroniser, 2-cycle latency. When loopback=1, its input is ser_out instead of ser_in. Changing loopback is only legal while both FSMs are IDLE.
- RX FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; WAIT_HIGH is entered on framing error.
  - IDLE: a synchronised high-to-low transition moves to START with counter=0.
  - START: sample at counter = CLKS_PER_BIT/2-1. If the line is high, treat as a glitch and return to IDLE with no output. If low, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, shifting in LSB first.
  - STOP sampled high: the word goes to the holding register.
  - STOP sampled low: frame_err pulses one cycle, the word is discarded, and the FSM goes to WAIT_HIGH. WAIT_HIGH returns to IDLE on the first sampled 1.
- Holding register:
  - rx_valid&rx_ready clears rx_valid on the next cycle.
  - A new word arriving while rx_valid=1 and not consumed that cycle sets overrun and overwrites rx_data; rx_valid stays 1.
  - If a new word arrives in the same cycle rx_ready consumes the old one, the new word is loaded, rx_valid stays 1, and there is no overrun.
- Loopback latency from tx acceptance to rx_valid = F - CLKS_PER_BIT/2 + 4 cycles (±1 is permitted for the implementation, but the value must be constant and documented in the RTL header).

Optional Feature:
- Macro: SER_DES_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of data bits) is inserted between the data and stop bits, and F grows by CLKS_PER_BIT.
  - RX checks parity and adds output port parity_err (1 bit), a one-cycle pulse on mismatch, raised together with rx_valid.
  - The word is still delivered.
- Undefined: no parity bit and no parity_err port. The frame is exactly DATA_W+2 bits.

Test Plan:
- Reset/idle: hold reset 5 cycles, release -> ser_out=1, tx_ready=1, rx_valid=0, overrun=0 for 50 cycles.
- Loopback single word: DATA_W=8, CLKS_PER_BIT=4, loopback=1, send 8'hA5 with rx_ready=1.
  - ser_out pattern is 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit.
  - rx_data=8'hA5 with rx_valid exactly once at the documented latency.
- Back-to-back stream: tx_valid held high over words 00,FF,3C,C3,81.
  - No idle gap between frames.
  - All 5 words received in order; frame_err=0.
- Overrun: rx_ready=0, send 11 then 22 -> overrun=1, rx_data=8'h22, rx_valid=1. Assert rx_ready -> rx_valid=0 next cycle; overrun stays 1.
- Line faults (loopback=0):
  - A 1-cycle low glitch on ser_in produces no rx_valid.
  - A frame with stop bit 0 produces a frame_err pulse and no rx_valid, then recovery. The next valid frame 8'h5A is received correctly.
- Parity (SER_DES_PARITY_EN): send 8'h07 with a corrupted parity bit on ser_in -> parity_err=1 with rx_valid, rx_data=8'h07. A correct frame gives parity_err=0.

Source files
------------

// File: rtl/ser_des_link_if.sv
// rtl/ser_des_link_if.sv - Parallel-side TX/RX handshake bundle for ser_des_link
// parity_err exists only when SER_DES_PARITY_EN is defined.
interface ser_des_link_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              frame_err;
    logic              overrun;
`ifdef SER_DES_PARITY_EN
    logic              parity_err;
`endif

    modport master (
        output tx_data, tx_valid, rx_ready,
`ifdef SER_DES_PARITY_EN
        input  parity_err,
`endif
        input  tx_ready, rx_data, rx_valid, frame_err, overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
`ifdef SER_DES_PARITY_EN
        output parity_err,
`endif
        output tx_ready, rx_data, rx_valid, frame_err, overrun
    );
endinterface

// File: rtl/ser_des_link.sv
// rtl/ser_des_link.sv - Parametrised full-duplex NRZ serializer/deserializer with internal loopback
// Optional even parity via SER_DES_PARITY_EN. Loopback latency, tx accept cycle -> first rx_valid cycle: exactly F - CLKS_PER_BIT/2 + 4.
module ser_des_link #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    ser_des_link_if.slave link,
    output logic          ser_out,
    input  logic          ser_in,
    input  logic          loopback
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    tx_state_t         tx_state;
    logic [DATA_W-1:0] tx_shift;
    logic [CNT_W-1:0]  tx_cnt;
    logic [IDX_W-1:0]  tx_idx;
    logic              tx_ready_q;
    logic              tx_accept;
`ifdef SER_DES_PARITY_EN
    logic              tx_par;
`endif

    assign tx_accept     = link.tx_valid & tx_ready_q;
    assign link.tx_ready = tx_ready_q;

    // tx_ready re-opens on the final stop cycle so an accept there starts the next frame with no gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            tx_ready_q <= 1'b1;
            ser_out    <= 1'b1;
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_shift   <= '0;
`ifdef SER_DES_PARITY_EN
            tx_par     <= 1'b0;
`endif
        end else if (tx_accept) begin
            tx_state   <= TX_START;
            tx_ready_q <= 1'b0;
            ser_out    <= 1'b0;
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_shift   <= link.tx_data;
`ifdef SER_DES_PARITY_EN
            tx_par     <= ^link.tx_data;
`endif
        end else begin
            tx_cnt <= (tx_cnt == CNT_LAST) ? '0 : tx_cnt + 1'b1;
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt <= '0;
                end
                TX_START: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_state <= TX_DATA;
                        ser_out  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == CNT_LAST) begin
                        if (tx_idx == IDX_LAST) begin
`ifdef SER_DES_PARITY_EN
                            tx_state <= TX_PARITY;
                            ser_out  <= tx_par;
`else
                            tx_state <= TX_STOP;
                            ser_out  <= 1'b1;
`endif
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            ser_out  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_state <= TX_STOP;
                        ser_out  <= 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == CNT_PRE) begin
                        tx_ready_q <= 1'b1;
                    end
                    if (tx_cnt == CNT_LAST) begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    ser_out  <= 1'b1;
                end
            endcase
        end
    end

    logic              line_in;
    logic              sync1;
    logic              sync2;
    logic              rx_prev;
    rx_state_t         rx_state;
    logic [CNT_W-1:0]  rx_cnt;
    logic [IDX_W-1:0]  rx_idx;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              frame_err_q;
    logic              overrun_q;
`ifdef SER_DES_PARITY_EN
    logic              rx_par_bit;
    logic              parity_err_q;

    assign link.parity_err = parity_err_q;
`endif

    assign line_in        = loopback ? ser_out : ser_in;
    assign link.rx_data   = rx_data_q;
    assign link.rx_valid  = rx_valid_q;
    assign link.frame_err = frame_err_q;
    assign link.overrun   = overrun_q;

    // sync2 is the synchronised line; rx_prev lets IDLE spot a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1        <= 1'b1;
            sync2        <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SER_DES_PARITY_EN
            rx_par_bit   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1       <= line_in;
            sync2       <= sync1;
            rx_prev     <= sync2;
            frame_err_q <= 1'b0;
`ifdef SER_DES_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (rx_valid_q && link.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            rx_cnt <= (rx_cnt == CNT_LAST) ? '0 : rx_cnt + 1'b1;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_prev && !sync2) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == CNT_MID) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= sync2 ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_shift <= {sync2, rx_shift[DATA_W-1:1]};
                        if (rx_idx == IDX_LAST) begin
`ifdef SER_DES_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt == CNT_LAST) begin
`ifdef SER_DES_PARITY_EN
                        rx_par_bit <= sync2;
`endif
                        rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == CNT_LAST) begin
                        if (sync2) begin
                            // A same-cycle consume frees the register, so only an unconsumed word overruns.
                            rx_data_q  <= rx_shift;
                            rx_valid_q <= 1'b1;
                            if (rx_valid_q && !link.rx_ready) begin
                                overrun_q <= 1'b1;
                            end
`ifdef SER_DES_PARITY_EN
                            parity_err_q <= (^rx_shift) ^ rx_par_bit;
`endif
                            rx_state <= RX_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            rx_state    <= RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (sync2) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule
